led_fx_driver: RTL

Output stage placed directly downstream of the 18-bit LED PIO in the Nios system: consumes the PIO's registered LED pattern and drives the board LED pins. Adds per-LED blinking and global PWM dimming, configured by the CPU over a small Avalon-MM slave. With effects disabled, the pattern passes through with one cycle of latency, so existing software keeps working.

---
 rtl/led_fx_pkg.sv | 30 +++
 rtl/led_fx_timebase.sv | 47 ++++
 rtl/led_fx_driver.sv | 102 ++++++++++
 3 files changed

// File: rtl/led_fx_pkg.sv
// Shared constants for the LED effects output stage: register map, CTRL fields,
// LED width and reset defaults.
package led_fx_pkg;

    localparam int LED_W = 18;
    localparam int DIV_W = 24;
    localparam int PWM_W = 8;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_FX_EN_BIT   = 0;
    localparam int CTRL_PWM_EN_BIT  = 1;
    localparam int CTRL_DUTY_LSB    = 8;
    localparam int CTRL_DUTY_MSB    = 15;
    localparam int STATUS_PHASE_BIT = 0;

    localparam int               PRESCALE_DEF  = 50000;
    localparam logic [DIV_W-1:0] BLINK_DIV_DEF = 24'd499;
    localparam logic [PWM_W-1:0] DUTY_FULL     = 8'hFF;

    typedef struct packed {
        logic [PWM_W-1:0] duty;
        logic             pwm_en;
        logic             fx_en;
    } ctrl_t;

endpackage

// File: rtl/led_fx_timebase.sv
// Blink timebase: a prescaler producing a one-cycle tick, and a blink counter
// that toggles phase every BLINK_DIV+1 ticks. restart re-aligns everything.
module led_fx_timebase
    import led_fx_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] blink_div,
    input  logic             restart,
    output logic             tick,
    output logic             phase
);

    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]  pre_cnt;
    logic [DIV_W-1:0] blink_cnt;

    assign tick = (pre_cnt == PS_LAST);

    // restart is checked first so it wins over a coincident tick or toggle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (restart) begin
            pre_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                if (blink_cnt == blink_div) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/led_fx_driver.sv
// LED pin driver behind the LED PIO: pass-through with optional per-LED blink
// and global PWM dimming, configured through a 4-register Avalon-MM slave.
module led_fx_driver
    import led_fx_pkg::*;
#(
    parameter int               PRESCALE      = PRESCALE_DEF,
    parameter logic [DIV_W-1:0] BLINK_DIV_RST = BLINK_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [LED_W-1:0] led_in,
    output logic [LED_W-1:0] led_out
);

    ctrl_t            ctrl;
    logic [LED_W-1:0] blink_mask;
    logic [DIV_W-1:0] blink_div;
    logic [PWM_W-1:0] pwm_cnt;
    logic             wr_en;
    logic             restart;
    logic             tick;
    logic             phase;
    logic             pwm_on;
    logic [LED_W-1:0] led_next;

    // Writes have no wait state: accepted on any edge with chipselect high
    // and write_n low. Reads are combinational and ignore chipselect.
    assign wr_en   = chipselect && !write_n;
    assign restart = wr_en && (address == ADDR_DIV);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl       <= '0;
            blink_mask <= '0;
            blink_div  <= BLINK_DIV_RST;
        end else if (wr_en) begin
            case (address)
                ADDR_CTRL: begin
                    ctrl.fx_en  <= writedata[CTRL_FX_EN_BIT];
                    ctrl.pwm_en <= writedata[CTRL_PWM_EN_BIT];
                    ctrl.duty   <= writedata[CTRL_DUTY_MSB:CTRL_DUTY_LSB];
                end
                ADDR_MASK: blink_mask <= writedata[LED_W-1:0];
                ADDR_DIV:  blink_div  <= writedata[DIV_W-1:0];
                default: ;
            endcase
        end
    end

    led_fx_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk       (clk),
        .reset_n   (reset_n),
        .blink_div (blink_div),
        .restart   (restart),
        .tick      (tick),
        .phase     (phase)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pwm_cnt <= '0;
        else          pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Full duty is special-cased so 255 means always on rather than 255/256
    assign pwm_on = (ctrl.duty == DUTY_FULL) || (pwm_cnt < ctrl.duty);

    always_comb begin
        led_next = led_in;
        if (ctrl.fx_en) begin
            led_next = led_in & ~(blink_mask & {LED_W{~phase}})
                              & {LED_W{pwm_on | ~ctrl.pwm_en}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) led_out <= '0;
        else          led_out <= led_next;
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_FX_EN_BIT]                = ctrl.fx_en;
                readdata[CTRL_PWM_EN_BIT]               = ctrl.pwm_en;
                readdata[CTRL_DUTY_MSB:CTRL_DUTY_LSB]   = ctrl.duty;
            end
            ADDR_MASK:   readdata[LED_W-1:0]        = blink_mask;
            ADDR_DIV:    readdata[DIV_W-1:0]        = blink_div;
            ADDR_STATUS: readdata[STATUS_PHASE_BIT] = phase;
            default: ;
        endcase
    end

endmodule
